// File: rtl/alu_result_sel_if.sv
// Request/response bundle between the issue logic and the result selector.
// The requester is the master; the selector is the slave.
interface alu_result_sel_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       func;
  logic [WIDTH-1:0] alu_in;
  logic [WIDTH-1:0] shift_in;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;

  modport master (
    output req_valid, func, alu_in, shift_in,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, func, alu_in, shift_in,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/alu_result_sel.sv
// Writeback result selector: routes ALU/shift/HI/LO by funct,
// owns HI/LO and sequences the multi-cycle MDU with a timeout.
module alu_result_sel #(
  parameter int WIDTH       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  alu_result_sel_if.slave  req,
  input  logic [WIDTH-1:0] mdu_hi,
  input  logic [WIDTH-1:0] mdu_lo,
  input  logic             mdu_done,
  output logic             mdu_start,
  output logic             mdu_op,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);
  localparam int CW = $clog2(MDU_TIMEOUT + 1);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;

  logic             is_alu;
  logic             is_sll;
  logic             is_mfhi;
  logic             is_mflo;
  logic             is_divu;
  logic             is_multu;
  logic             is_mdu;
  logic             unknown;
  logic             accept;
  logic             launch;
  logic             timeout;
  logic [WIDTH-1:0] sel_data;

  assign is_alu   = req.func inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT};
  assign is_sll   = req.func == F_SLL;
  assign is_mfhi  = req.func == F_MFHI;
  assign is_mflo  = req.func == F_MFLO;
  assign is_divu  = req.func == F_DIVU;
  assign is_multu = req.func == F_MULTU;
  assign is_mdu   = is_divu | is_multu;
  assign unknown  = ~(is_alu | is_sll | is_mfhi | is_mflo | is_mdu);

  assign accept  = req.req_valid & req.req_ready;
  assign launch  = accept & is_mdu;
  assign timeout = (state == BUSY) & ~mdu_done
                 & (cnt == CW'(MDU_TIMEOUT - 1));

  assign hi_q = hi;
  assign lo_q = lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (launch) state_nx = BUSY;
      BUSY: if (mdu_done | timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // HI/LO readers and new MDU ops must wait for the op in flight
  always_comb begin
    req.req_ready = (state == IDLE) | ~(is_mdu | is_mfhi | is_mflo);
    sel_data      = '0;
    unique case (1'b1)
      is_alu:  sel_data = req.alu_in;
      is_sll:  sel_data = req.shift_in;
      is_mfhi: sel_data = hi;
      is_mflo: sel_data = lo;
      default: sel_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi             <= '0;
      lo             <= '0;
      cnt            <= '0;
      mdu_start      <= 1'b0;
      mdu_op         <= 1'b0;
      req.resp_valid <= 1'b0;
      req.resp_data  <= '0;
      req.resp_err   <= 1'b0;
    end else begin
      req.resp_valid <= accept;
      req.resp_err   <= (accept & unknown) | timeout;
      mdu_start      <= launch;
      if (accept) req.resp_data <= sel_data;
      if (launch) begin
        mdu_op <= is_multu;
        cnt    <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == BUSY) & mdu_done) begin
        hi <= mdu_hi;
        lo <= mdu_lo;
      end
    end
  end
endmodule
